// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and width helpers for the multi-channel divider.
package divider_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam int WIDTH_DEF = 12;
   localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration on {P, A} against divisor B.
module divider_step #(
   parameter int WIDTH = 12
)(
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] next_p,
   output logic [WIDTH-1:0] next_a
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] t;

   // P < B always holds, so the trial difference fits in WIDTH+1 signed bits.
   always_comb begin
      sh     = {p, a[WIDTH-1]};
      t      = sh - {1'b0, b};
      next_p = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
      next_a = {a[WIDTH-2:0], ~t[WIDTH]};
   end

endmodule

// File: rtl/divider_mc.sv
// divider_mc: multi-channel restoring divider, one quotient bit per cycle,
// unsigned or two's-complement, with divide-by-zero flag and one-cycle ready.
module divider_mc
   import divider_pkg::*;
#(
   parameter  int WIDTH = 12,
   parameter  int NCH   = 2,
   localparam int SEL_W = sel_width(NCH)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SEL_W-1:0]   sel,
   input  logic               signed_mode,
   input  logic [NCH*WIDTH-1:0] dividend,
   input  logic [NCH*WIDTH-1:0] divisor,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic [SEL_W-1:0]   ch_out,
   output logic               busy,
   output logic               ready
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] p, a, b;
   logic [WIDTH-1:0] next_p, next_a;
   logic [WIDTH-1:0] op_a, op_b;
   logic [SEL_W-1:0] ch_sel, ch;
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg, dbz;
   logic             sa, sb;

   always_comb begin
      ch_sel = (int'(sel) < NCH) ? sel : '0;
      op_a   = dividend[int'(ch_sel)*WIDTH +: WIDTH];
      op_b   = divisor[int'(ch_sel)*WIDTH +: WIDTH];
      sa     = signed_mode & op_a[WIDTH-1];
      sb     = signed_mode & op_b[WIDTH-1];
   end

   divider_step #(.WIDTH(WIDTH)) u_step (
      .p      (p),
      .a      (a),
      .b      (b),
      .next_p (next_p),
      .next_a (next_a)
   );

   // On divide-by-zero A keeps the raw dividend so it can be returned untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         p           <= '0;
         a           <= '0;
         b           <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dbz         <= 1'b0;
         ch          <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         ch_out      <= '0;
         busy        <= 1'b0;
         ready       <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a     <= (op_b == '0) ? op_a : (sa ? -op_a : op_a);
               b     <= sb ? -op_b : op_b;
               p     <= '0;
               cnt   <= '0;
               q_neg <= sa ^ sb;
               r_neg <= sa;
               dbz   <= (op_b == '0);
               ch    <= ch_sel;
               busy  <= 1'b1;
               state <= (op_b == '0) ? FIX : CALC;
            end
            CALC: begin
               p     <= next_p;
               a     <= next_a;
               cnt   <= cnt + 1'b1;
               state <= (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
               quotient    <= dbz ? '1 : (q_neg ? -a : a);
               remainder   <= dbz ? a : (r_neg ? -p : p);
               div_by_zero <= dbz;
               ch_out      <= ch;
               ready       <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
